flip_flop_fifo_levels: RTL and testbench
========================================

# flip_flop_fifo_levels

Parametrised flip-flop FIFO, next generation of the empty/full-optimised FIFO: arbitrary (non-power-of-two) depth, wrap-bit pointers, registered occupancy level, almost-full/almost-empty thresholds, guarded push/pop, sticky overflow/underflow errors, and synchronous flush. It sits between a producer and consumer in the same clock domain, buffering up to `depth` words with show-ahead read data.

## Interface
- `width`, 8: data word width in bits, ≥1.
- `depth`, 10: storage entries, ≥2; any integer.
- `almost_full_level`, depth-2: `almost_full` asserts when level ≥ this value; range 1..depth.
- `almost_empty_level`, 1: `almost_empty` asserts when level ≤ this value; range 0..depth-1.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `push` input 1: write request.
- `pop` input 1: read request.
- `flush` input 1: synchronous clear of contents.
- `clear_err` input 1: synchronous clear of sticky error flags.
- `write_data` input width: word written on accepted push.
- `read_data` output width: word at head (show-ahead); undefined when empty.
- `empty` output 1: no words stored.
- `full` output 1: depth words stored.
- `almost_empty` output 1: level ≤ almost_empty_level.
- `almost_full` output 1: level ≥ almost_full_level.
- `level` output $clog2(depth+1): current occupancy.
- `overflow` output 1: sticky, push attempted while full.
- `underflow` output 1: sticky, pop attempted while empty.

## Operation
- Pointers: `wr_ptr`, `rd_ptr` of $clog2(depth) bits each, plus wrap bit; index depth-1 wraps to 0 and toggles wrap bit.
- `empty` = pointers equal & wrap bits equal; `full` = pointers equal & wrap bits differ. Both decoded from registers only.
- Accepted push: `push & ~full`. Accepted pop: `pop & ~empty`. Rejected requests change no pointer, data, or level.
- Simultaneous push & pop: each judged against current flags independently. Not full, not empty: both accepted, level unchanged. Full: pop accepted, push rejected with `overflow` set. Empty: push accepted, pop rejected with `underflow` set.
- `level`: registered counter; +1 on push-only, -1 on pop-only, unchanged on both or neither. It always equals occupancy implied by pointers.
- `almost_full`/`almost_empty`: combinational compares on registered `level`.
- `flush` has priority over push/pop: pointers, wrap bits, and level go to 0; storage is untouched. Push/pop in the flush cycle are ignored and flag no error.
- `overflow`/`underflow`: set on rejected request; hold until `clear_err` or reset. Set wins over `clear_err` in the same cycle.
- Storage (`data[0:depth-1]`): not reset; written at `wr_ptr` on accepted push.

## Timing
- Reset (async assert, sync-released by system): pointers and wrap bits 0, `level`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
- Write-to-read latency is one cycle. A word pushed at edge N is visible on `read_data` after edge N when the FIFO was empty.
- `read_data` updates combinationally from `rd_ptr`; next word is visible after the popping edge.
- All flags and `level` change only after a clock edge or async reset; there is no input-to-flag combinational path.
- Reset asserted mid-operation discards contents immediately; outputs reach reset values without a clock.

## Structure
- Package `flip_flop_fifo_pkg`: function `fifo_ptr_w(depth)` and `fifo_level_w(depth)` (clog2 helpers); no typedefs depend on instance parameters.
- Sub-module `fifo_wrap_ptr`, parameter `depth`: inputs `clk`, `rst_n`, `inc`, `clr`; outputs `ptr`, `wrap`. It is instantiated twice, once for the read side and once for the write side.
- Parameter legality checked with elaboration-time `$error`.

## Test plan
- depth=5, width=8. Reset, then push 0x11,0x22,0x33 → `read_data`=0x11, `level`=3, `empty`=0, `almost_empty`=0.
- Fill to 5 words, then push 0x99 → `full`=1, `level`=5, `overflow`=1 sticky. Pop all 5 → data in order, 0x99 never appears.
- Empty FIFO, pop → `underflow`=1, `level`=0. Assert `clear_err` → `underflow`=0 next cycle.
- Run 12 push/pop cycles across the 4→0 wrap → data order preserved, `level` tracks expected count, `full`/`empty` correct at wrap.
- Full FIFO, push & pop together → head popped, push rejected, `level`=4, `overflow`=1. Half-full with both → `level` unchanged.
- Level 3, assert `flush` with push → `level`=0, `empty`=1, no error. Assert `rst_n` low mid-stream → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/flip_flop_fifo_pkg.sv
// Shared sizing helpers for the flip-flop FIFO with occupancy levels.
package flip_flop_fifo_pkg;

  // Bits needed to index depth entries (depth >= 2).
  function automatic int unsigned fifo_ptr_w(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to represent an occupancy of 0..depth.
  function automatic int unsigned fifo_level_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flip_flop_fifo_levels_if.sv
// Producer/consumer bundle for flip_flop_fifo_levels.
interface flip_flop_fifo_levels_if #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 10
);
  import flip_flop_fifo_pkg::*;

  localparam int unsigned LvlW = fifo_level_w(depth);

  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [width-1:0] write_data;
  logic [width-1:0] read_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [LvlW-1:0]  level;
  logic             overflow;
  logic             underflow;

  // User side: drives requests, observes data and status.
  modport master (
    output push, pop, flush, clear_err, write_data,
    input  read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  push, pop, flush, clear_err, write_data,
    output read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-depth pointer with a wrap bit that toggles each time the index rolls over.
module fifo_wrap_ptr
  import flip_flop_fifo_pkg::*;
#(
  parameter int unsigned depth = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         clr,
  output logic [fifo_ptr_w(depth)-1:0] ptr,
  output logic                         wrap
);

  localparam int unsigned PtrW = fifo_ptr_w(depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(depth - 1);

  logic [PtrW-1:0] ptr_d, ptr_q;
  logic            wrap_d, wrap_q;

  // Next pointer: clear wins, otherwise advance with wrap at depth-1.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    if (clr) begin
      ptr_d  = '0;
      wrap_d = 1'b0;
    end else if (inc) begin
      if (ptr_q == LastIdx) begin
        ptr_d  = '0;
        wrap_d = ~wrap_q;
      end else begin
        ptr_d = ptr_q + PtrW'(1);
      end
    end
  end

  // Pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr  = ptr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/flip_flop_fifo_levels.sv
// Flip-flop FIFO of arbitrary depth with show-ahead read, registered level,
// almost thresholds, sticky overflow/underflow and synchronous flush.
module flip_flop_fifo_levels
  import flip_flop_fifo_pkg::*;
#(
  parameter int unsigned width              = 8,
  parameter int unsigned depth              = 10,
  parameter int unsigned almost_full_level  = depth - 2,
  parameter int unsigned almost_empty_level = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  flip_flop_fifo_levels_if.slave bus
);

  localparam int unsigned PtrW = fifo_ptr_w(depth);
  localparam int unsigned LvlW = fifo_level_w(depth);
  localparam logic [LvlW-1:0] AfLvl = LvlW'(almost_full_level);
  localparam logic [LvlW-1:0] AeLvl = LvlW'(almost_empty_level);

  if (width < 1) begin : g_bad_width
    $error("flip_flop_fifo_levels: width must be >= 1");
  end
  if (depth < 2) begin : g_bad_depth
    $error("flip_flop_fifo_levels: depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_afl
    $error("flip_flop_fifo_levels: almost_full_level must be in 1..depth");
  end
  if (almost_empty_level > depth - 1) begin : g_bad_ael
    $error("flip_flop_fifo_levels: almost_empty_level must be in 0..depth-1");
  end

  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             wr_wrap, rd_wrap;
  logic             empty, full;
  logic             push_ok, pop_ok;
  logic [LvlW-1:0]  level_d, level_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic [width-1:0] data_d [depth];
  logic [width-1:0] data_q [depth];

  // Flags come from registered pointers only.
  assign empty = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
  assign full  = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);

  // Flush swallows any request in the same cycle.
  assign push_ok = bus.push & ~full & ~bus.flush;
  assign pop_ok  = bus.pop & ~empty & ~bus.flush;

  fifo_wrap_ptr #(
    .depth (depth)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_ok),
    .clr   (bus.flush),
    .ptr   (wr_ptr),
    .wrap  (wr_wrap)
  );

  fifo_wrap_ptr #(
    .depth (depth)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_ok),
    .clr   (bus.flush),
    .ptr   (rd_ptr),
    .wrap  (rd_wrap)
  );

  // Next level and sticky error flags; a new error outranks clear_err.
  always_comb begin
    level_d = level_q;
    if (bus.flush) begin
      level_d = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
    overflow_d  = (overflow_q & ~bus.clear_err) | (bus.push & full & ~bus.flush);
    underflow_d = (underflow_q & ~bus.clear_err) | (bus.pop & empty & ~bus.flush);
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage next state: only the write slot changes, and only on an accepted push.
  always_comb begin
    data_d = data_q;
    if (push_ok) begin
      data_d[wr_ptr] = bus.write_data;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.read_data    = data_q[rd_ptr];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.level        = level_q;
  assign bus.almost_full  = (level_q >= AfLvl);
  assign bus.almost_empty = (level_q <= AeLvl);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_flip_flop_fifo_levels.sv
// Randomised and directed bench for flip_flop_fifo_levels against a queue model.
module tb_flip_flop_fifo_levels;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 5;
  localparam int unsigned Afl   = 3;
  localparam int unsigned Ael   = 1;

  logic clk;
  logic rst_n;

  flip_flop_fifo_levels_if #(.width(Width), .depth(Depth)) bus ();

  flip_flop_fifo_levels #(
    .width              (Width),
    .depth              (Depth),
    .almost_full_level  (Afl),
    .almost_empty_level (Ael)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [Width-1:0] model_q[$];
  bit               m_ov;
  bit               m_un;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check({tag, ".empty"}, bus.empty, (sz == 0));
    check({tag, ".full"}, bus.full, (sz == Depth));
    check({tag, ".level"}, bus.level, sz);
    check({tag, ".aempty"}, bus.almost_empty, (sz <= Ael));
    check({tag, ".afull"}, bus.almost_full, (sz >= Afl));
    check({tag, ".ovf"}, bus.overflow, m_ov);
    check({tag, ".unf"}, bus.underflow, m_un);
    if (sz != 0) check({tag, ".rdata"}, bus.read_data, model_q[0]);
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ov = 0;
    m_un = 0;
  endtask

  // One clock with the given request; model updated from pre-edge contents.
  task automatic cycle(input bit p, input bit o, input bit f, input bit c,
                       input logic [Width-1:0] d, input string tag);
    bit was_full, was_empty;
    bus.push       = p;
    bus.pop        = o;
    bus.flush      = f;
    bus.clear_err  = c;
    bus.write_data = d;
    was_full  = (model_q.size() == Depth);
    was_empty = (model_q.size() == 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
      m_ov = m_ov && !c;
      m_un = m_un && !c;
    end else begin
      m_ov = (m_ov && !c) || (p && was_full);
      m_un = (m_un && !c) || (o && was_empty);
      if (o && !was_empty) void'(model_q.pop_front());
      if (p && !was_full) model_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.push = 0; bus.pop = 0; bus.flush = 0; bus.clear_err = 0; bus.write_data = '0;
    model_reset();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three pushes, head visible.
    cycle(1, 0, 0, 0, 8'h11, "push11");
    check("first_word", bus.read_data, 8'h11);
    cycle(1, 0, 0, 0, 8'h22, "push22");
    cycle(1, 0, 0, 0, 8'h33, "push33");
    check("lvl3", bus.level, 3);

    // Fill, then overflow attempt.
    cycle(1, 0, 0, 0, 8'h44, "push44");
    cycle(1, 0, 0, 0, 8'h55, "push55");
    cycle(1, 0, 0, 0, 8'h99, "push99");
    check("ovf_set", bus.overflow, 1);
    check("full_set", bus.full, 1);

    // Full with push+pop: pop wins, push rejected.
    cycle(1, 1, 0, 0, 8'hAA, "full_both");
    check("full_both_lvl", bus.level, 4);

    // Drain; 0x99/0xAA never appear.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00, "drain");
    check("drained", bus.empty, 1);

    // Underflow and clear.
    cycle(0, 1, 0, 0, 8'h00, "unf_pop");
    check("unf_set", bus.underflow, 1);
    cycle(0, 0, 0, 1, 8'h00, "clr_err");
    check("unf_clr", bus.underflow, 0);

    // Wrap traffic with overlapping push/pop.
    for (int i = 0; i < 12; i++) cycle(1, (i % 3) != 0, 0, 0, 8'(8'hC0 + i), "wrap");

    // Level 3 then flush together with push: no error.
    while (model_q.size() > 3) cycle(0, 1, 0, 0, 8'h00, "trim");
    while (model_q.size() < 3) cycle(1, 0, 0, 0, 8'h5A, "grow");
    cycle(1, 1, 0, 0, 8'h66, "half_both");
    cycle(1, 0, 1, 0, 8'h77, "flush");
    check("flush_empty", bus.empty, 1);

    // Random traffic with rare flush/clear.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
            8'($urandom), "rand");
    end

    // Async reset mid-stream: outputs at reset values before any edge.
    cycle(1, 0, 0, 0, 8'hE1, "pre_rst");
    cycle(1, 0, 0, 0, 8'hE2, "pre_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 8'h3C, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
